audio_playout_scheduler: RTL and testbench

Sequences sample playout from the left and right audio FIFOs to the DAC at a fixed output sample rate. Gates playout start on FIFO prefill. Pops both channels in lockstep so stereo alignment is never lost. Applies per-channel gain and mute with saturation, and detects underruns, returning to prefill after a run of starved ticks.

---
 rtl/audio_playout_scheduler.sv | 111 +++++++++++
 tb/tb_audio_playout_scheduler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/audio_playout_scheduler.sv
// audio_playout_scheduler: paces stereo FIFO playout to a fixed DAC rate with prefill gating,
// lockstep pops, gain/mute saturation and underrun recovery.
module audio_playout_scheduler #(
  parameter int CLK_HZ         = 30000000,
  parameter int SAMPLE_HZ      = 44100,
  parameter int UNDERRUN_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] l_sample,
  input  logic [15:0] r_sample,
  input  logic        l_write,
  input  logic        r_write,
  output logic        l_strobe,
  output logic        r_strobe,
  input  logic        l_nearly_full,
  input  logic        r_nearly_full,
  input  logic [7:0]  gain_l,
  input  logic [7:0]  gain_r,
  input  logic        mute,
  output logic [15:0] dac_left,
  output logic [15:0] dac_right,
  output logic        dac_valid,
  output logic        playing,
  output logic [15:0] underrun_count
);
  typedef enum logic [2:0] {PREFILL, WAIT_TICK, FETCH, APPLY, OUTPUT} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_acc, w_sum;
  logic        r_tick, r_from_prefill, w_pop, w_both;
  logic [15:0] r_l_hold, r_r_hold, r_starve;

  function automatic logic [15:0] scale(input logic [15:0] s, input logic [7:0] g, input logic m);
    logic signed [24:0] p;
    p = $signed(s) * $signed({1'b0, g});
    p = p >>> 7;
    return m ? 16'h0000 : p > 25'sd32767 ? 16'h7fff : p < -25'sd32768 ? 16'h8000 : p[15:0];
  endfunction

  assign w_sum  = r_acc + 32'(SAMPLE_HZ);
  assign w_both = l_write && r_write;

  always_ff @(posedge clk)
    if (reset) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_sum >= 32'(CLK_HZ);
      r_acc  <= w_sum >= 32'(CLK_HZ) ? w_sum - 32'(CLK_HZ) : w_sum;
    end

  always_ff @(posedge clk)
    r_state <= reset ? PREFILL : w_next;

  // Prefill readiness beats a coincident tick; ticks in other states are dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      PREFILL:   w_next = (l_nearly_full && r_nearly_full) ? WAIT_TICK : r_tick ? OUTPUT : PREFILL;
      WAIT_TICK: w_next = r_tick ? FETCH : WAIT_TICK;
      FETCH:     w_next = APPLY;
      APPLY:     w_next = OUTPUT;
      OUTPUT:    w_next = (r_starve >= 16'(UNDERRUN_LIMIT) || r_from_prefill) ? PREFILL : WAIT_TICK;
      default:   w_next = PREFILL;
    endcase
  end

  always_comb begin
    w_pop     = r_state == FETCH && w_both && !reset;
    l_strobe  = w_pop;
    r_strobe  = w_pop;
    dac_valid = r_state == OUTPUT;
    playing   = r_state != PREFILL;
  end

  always_ff @(posedge clk)
    if (reset) begin
      r_l_hold       <= '0;
      r_r_hold       <= '0;
      r_starve       <= '0;
      r_from_prefill <= 1'b0;
      underrun_count <= '0;
      dac_left       <= '0;
      dac_right      <= '0;
    end else begin
      if (r_state == PREFILL) r_from_prefill <= 1'b1;
      else if (r_state == WAIT_TICK) r_from_prefill <= 1'b0;
      if (r_state == PREFILL && w_next == OUTPUT) begin
        dac_left  <= '0;
        dac_right <= '0;
      end
      // A one-sided starve pops nothing, keeping both channels on the same sample index.
      if (r_state == FETCH && w_both) begin
        r_l_hold <= l_sample;
        r_r_hold <= r_sample;
        r_starve <= '0;
      end else if (r_state == FETCH) begin
        underrun_count <= underrun_count == 16'hffff ? underrun_count : underrun_count + 16'd1;
        r_starve       <= r_starve == 16'hffff ? r_starve : r_starve + 16'd1;
      end
      if (r_state == APPLY) begin
        dac_left  <= scale(r_l_hold, gain_l, mute);
        dac_right <= scale(r_r_hold, gain_r, mute);
      end
      if (r_state == OUTPUT && r_starve >= 16'(UNDERRUN_LIMIT)) begin
        r_starve <= '0;
        r_l_hold <= '0;
        r_r_hold <= '0;
      end
    end
endmodule

// File: tb/tb_audio_playout_scheduler.sv
// tb_audio_playout_scheduler: scoreboard bench; stimulus queues expected sample pairs,
// a monitor pops them on every dac_valid. A second default-rate instance checks pacing.
module tb_audio_playout_scheduler;
  logic        clk = 1'b0, reset, rate_reset;
  logic [15:0] ls, rs;
  logic        lw, rw, nf, mute;
  logic [7:0]  gl, gr;
  logic        l_strobe, r_strobe, dac_valid, playing;
  logic [15:0] dac_left, dac_right, underrun_count;
  logic        q_ls, q_rs, q_valid, q_playing;
  logic [15:0] q_left, q_right, q_uc;
  int          n_pass = 0, n_total = 0, rate_cnt = 0;
  bit          rate_done = 1'b0;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic [7:0]  pops;
    logic [15:0] uc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  audio_playout_scheduler #(.CLK_HZ(8), .SAMPLE_HZ(1), .UNDERRUN_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .l_sample(ls), .r_sample(rs), .l_write(lw), .r_write(rw),
    .l_strobe(l_strobe), .r_strobe(r_strobe), .l_nearly_full(nf), .r_nearly_full(nf),
    .gain_l(gl), .gain_r(gr), .mute(mute), .dac_left(dac_left), .dac_right(dac_right),
    .dac_valid(dac_valid), .playing(playing), .underrun_count(underrun_count));

  audio_playout_scheduler u_rate (
    .clk(clk), .reset(rate_reset), .l_sample(16'h0101), .r_sample(16'h0202), .l_write(1'b1),
    .r_write(1'b1), .l_strobe(q_ls), .r_strobe(q_rs), .l_nearly_full(1'b1), .r_nearly_full(1'b1),
    .gain_l(8'd128), .gain_r(8'd128), .mute(1'b0), .dac_left(q_left), .dac_right(q_right),
    .dac_valid(q_valid), .playing(q_playing), .underrun_count(q_uc));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic wait_out();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dac_valid && n < 40);
    if (!dac_valid) chk("timeout_dac_valid", dac_valid, 1);
  endtask

  task automatic run(input logic [15:0] l_in, r_in, input logic [7:0] gl_in, gr_in,
                     input logic m, lw_in, rw_in, input logic [15:0] el, er,
                     input logic [7:0] ep, input logic [15:0] euc);
    ls = l_in; rs = r_in; gl = gl_in; gr = gr_in; mute = m; lw = lw_in; rw = rw_in;
    q.push_back('{el, er, ep, euc});
    wait_out();
  endtask

  initial begin
    int lp = 0, rp = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        lp = 0;
        rp = 0;
      end else begin
        if (l_strobe) lp++;
        if (r_strobe) rp++;
        if (dac_valid) begin
          if (q.size() == 0) chk("unexpected_output", dac_valid, 0);
          else begin
            e = q.pop_front();
            chk("dac_left", dac_left, e.l);
            chk("dac_right", dac_right, e.r);
            chk("l_pops", lp, e.pops);
            chk("r_pops", rp, e.pops);
            chk("underrun_count", underrun_count, e.uc);
          end
          lp = 0;
          rp = 0;
        end
      end
    end
  end

  initial begin
    rate_reset = 1'b1;
    repeat (3) @(negedge clk);
    rate_reset = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (q_valid) rate_cnt++;
    end
    rate_done = 1'b1;
  end

  initial begin
    bit found = 1'b0;
    reset = 1'b1; nf = 1'b0; lw = 1'b1; rw = 1'b1; mute = 1'b0;
    ls = 16'h4000; rs = 16'h8000; gl = 8'd128; gr = 8'd128;
    repeat (3) @(negedge clk);
    chk("rst_dac_left", dac_left, 0);
    chk("rst_dac_right", dac_right, 0);
    chk("rst_dac_valid", dac_valid, 0);
    chk("rst_playing", playing, 0);
    chk("rst_underrun", underrun_count, 0);
    chk("rst_l_strobe", l_strobe, 0);
    chk("rst_r_strobe", r_strobe, 0);
    for (int i = 0; i < 5; i++) q.push_back('{16'h0, 16'h0, 8'd0, 16'd0});
    reset = 1'b0;
    for (int i = 0; i < 5; i++) wait_out();
    nf = 1'b1;
    run(16'h4000, 16'h8000, 128, 128, 0, 1, 1, 16'h4000, 16'h8000, 1, 0);
    run(16'h4000, 16'h8000, 255, 128, 0, 1, 1, 16'h7f80, 16'h8000, 1, 0);
    run(16'h6000, 16'h8000, 255,  64, 0, 1, 1, 16'h7fff, 16'hc000, 1, 0);
    run(16'hfffd, 16'h8000,   1, 255, 0, 1, 1, 16'hffff, 16'h8000, 1, 0);
    run(16'h1234, 16'h1111, 128, 128, 1, 1, 1, 16'h0000, 16'h0000, 1, 0);
    run(16'h1234, 16'h1111, 128, 128, 0, 1, 1, 16'h1234, 16'h1111, 1, 0);
    run(16'h5555, 16'h5555, 128, 128, 0, 1, 0, 16'h1234, 16'h1111, 0, 1);
    run(16'h0100, 16'h0200, 128, 128, 0, 1, 1, 16'h0100, 16'h0200, 1, 1);
    nf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run(16'h7777, 16'h7777, 128, 128, 0, 0, 0, 16'h0100, 16'h0200, 0, 16'(2 + i));
      @(negedge clk);
      chk("playing_after_output", playing, i < 3);
    end
    run(16'h7777, 16'h7777, 128, 128, 0, 0, 0, 16'h0000, 16'h0000, 0, 5);
    nf = 1'b1;
    run(16'h0abc, 16'h0def, 128, 128, 0, 0, 1, 16'h0000, 16'h0000, 0, 6);
    run(16'h0abc, 16'h0def, 128, 128, 0, 1, 1, 16'h0abc, 16'h0def, 1, 6);
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1 found = l_strobe;
    end
    chk("fetch_reached", found, 1);
    reset = 1'b1;
    #1;
    chk("fetch_rst_l_strobe", l_strobe, 0);
    chk("fetch_rst_r_strobe", r_strobe, 0);
    @(posedge clk);
    #1;
    chk("post_rst_dac_left", dac_left, 0);
    chk("post_rst_dac_right", dac_right, 0);
    chk("post_rst_dac_valid", dac_valid, 0);
    chk("post_rst_playing", playing, 0);
    chk("post_rst_underrun", underrun_count, 0);
    chk("post_rst_l_strobe", l_strobe, 0);
    for (int i = 0; i < 50000 && !rate_done; i++) @(negedge clk);
    chk("rate_window_done", rate_done, 1);
    chk("queue_empty", q.size(), 0);
    chk("rate_pulses", rate_cnt, 58);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
